// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with transfer locking and a single registered output
// stage. Requesters present beats (valid/last/data). A transfer is a run of
// beats ending with a beat that has last set. Once a requester's first
// non-last beat is accepted, it owns the output until its last beat is
// accepted. When no transfer is in progress, the winner is the first valid
// requester found by searching upward from a rotating priority pointer.
//
// Parameters
//   T        payload type carried from requesters to the output
//   NUM_REQ  number of requesters (2..32)
//
// Ports
//   clk_i           sole clock, rising edge
//   rst_i           synchronous active-high reset
//   req_valid_i     per-requester beat valid
//   req_last_i      per-requester last-beat flag, qualified by valid
//   req_data_i      per-requester payload (unpacked array of T)
//   req_ready_o     per-requester beat accepted this cycle (one-hot or zero)
//   out_valid_o     registered output beat valid
//   out_ready_i     downstream accepts the output beat
//   out_data_o      registered payload of the accepted beat
//   out_last_o      registered last flag of the accepted beat
//   out_grant_oh_o  registered one-hot source of the beat in the output reg
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter type T       = logic,
    parameter int  NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [NUM_REQ-1:0] req_last_i,
    input  T                   req_data_i [NUM_REQ-1:0],
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output T                   out_data_o,
    output logic               out_last_o,
    output logic [NUM_REQ-1:0] out_grant_oh_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int DATA_W = $bits(T);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     w_ptrNext;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     w_ownerNext;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grantIdx;
    logic                 w_loadEn;
    logic                 w_transfer;
    logic                 w_lastBeat;
    logic [DATA_W-1:0]    w_muxBits;

    logic                 r_outValid;
    T                     r_outData;
    logic                 r_outLast;
    logic [NUM_REQ-1:0]   r_outGrant;

    // The output register may take a new beat when it is empty or being
    // drained this same cycle.
    assign w_loadEn = !r_outValid || out_ready_i;

    // Grant selection. While locked only the owner is offered the slot, even
    // if it currently has nothing to send, so no other requester can slip a
    // beat into the middle of the owner's transfer. While idle the search
    // starts at the pointer and wraps past the top index back to zero.
    always_comb begin
        int  idx;
        logic found;
        w_grant    = '0;
        w_grantIdx = '0;
        idx        = 0;
        found      = 1'b0;
        if (r_state == LOCKED) begin
            w_grant[r_owner] = 1'b1;
            w_grantIdx       = r_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(r_ptr) + k) % NUM_REQ;
                if (!found && req_valid_i[idx]) begin
                    found        = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_grantIdx   = IDX_W'(idx);
                end
            end
        end
    end

    // Ready is forced low during reset so nothing is accepted while the
    // arbiter state is being cleared.
    assign req_ready_o = rst_i ? '0 : (w_grant & {NUM_REQ{w_loadEn}});
    assign w_transfer  = |(req_valid_i & req_ready_o);
    assign w_lastBeat  = req_last_i[w_grantIdx];

    // AND-OR one-hot payload mux: the grant is one-hot, so OR-ing the masked
    // payloads yields the selected one without any priority chain.
    always_comb begin
        w_muxBits = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_muxBits = w_muxBits | (DATA_W'(req_data_i[i]) & {DATA_W{w_grant[i]}});
        end
    end

    // Next-state logic. A non-last beat accepted while idle locks onto that
    // requester; any accepted last beat releases the lock and moves the
    // pointer just past the requester that finished.
    always_comb begin
        w_stateNext = r_state;
        w_ownerNext = r_owner;
        w_ptrNext   = r_ptr;
        if (w_transfer) begin
            if (w_lastBeat) begin
                w_stateNext = IDLE;
                w_ptrNext   = (w_grantIdx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : w_grantIdx + IDX_W'(1);
            end else if (r_state == IDLE) begin
                w_stateNext = LOCKED;
                w_ownerNext = w_grantIdx;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_owner <= w_ownerNext;
        end
    end

    // Output register stage. When loading without a transfer only the valid
    // flag drops; payload fields are left alone since they are meaningless
    // without valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
            r_outGrant <= '0;
        end else if (w_loadEn) begin
            r_outValid <= w_transfer;
            if (w_transfer) begin
                r_outData  <= T'(w_muxBits);
                r_outLast  <= w_lastBeat;
                r_outGrant <= w_grant;
            end
        end
    end

    assign out_valid_o    = r_outValid;
    assign out_data_o     = r_outData;
    assign out_last_o     = r_outLast;
    assign out_grant_oh_o = r_outGrant;

`ifdef COMM_ASSERT
    // Both the ready vector and the registered source must never name more
    // than one requester.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     $onehot0(req_ready_o) && $onehot0(out_grant_oh_o));
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Directed testbench for rr_arbiter with NUM_REQ = 4 and an 8-bit payload.
// Each scenario task drives its own stimulus and compares against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] reqValid;
    logic [3:0] reqLast;
    logic [7:0] reqData [3:0];
    logic [3:0] reqReady;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic       outLast;
    logic [3:0] outGrant;

    int nCompared   = 0;
    int nMismatched = 0;

    rr_arbiter #(
        .T       (logic [7:0]),
        .NUM_REQ (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (reqValid),
        .req_last_i     (reqLast),
        .req_data_i     (reqData),
        .req_ready_o    (reqReady),
        .out_valid_o    (outValid),
        .out_ready_i    (outReady),
        .out_data_o     (outData),
        .out_last_o     (outLast),
        .out_grant_oh_o (outGrant)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bring the DUT to a clean idle state with pointer at zero.
    task automatic doReset;
        rst      = 1'b1;
        reqValid = 4'b0000;
        reqLast  = 4'b0000;
        outReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Reset values, with every requester asserting during reset.
    task automatic test_reset;
        rst      = 1'b1;
        reqValid = 4'b1111;
        reqLast  = 4'b1111;
        outReady = 1'b1;
        tick();
        tick();
        nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", outValid); end
        nCompared++; if (outData !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_data: got %h want 00", outData); end
        nCompared++; if (outLast !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_last: got %b want 0", outLast); end
        nCompared++; if (outGrant !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_grant: got %b want 0000", outGrant); end
        nCompared++; if (reqReady !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b want 0000", reqReady); end
    endtask

    // All requesters valid with single-beat transfers: strict rotation,
    // one beat per cycle, first output one cycle after reset release.
    task automatic test_round_robin;
        logic [3:0] expG [5];
        logic [7:0] expD;
        expG = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            nCompared++; if (reqReady !== expG[k]) begin nMismatched++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", k, reqReady, expG[k]); end
            tick();
            expD = 8'h10 + 8'(k % 4);
            nCompared++; if (outValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rr_valid[%0d]: got %b want 1", k, outValid); end
            nCompared++; if (outGrant !== expG[k]) begin nMismatched++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", k, outGrant, expG[k]); end
            nCompared++; if (outData !== expD) begin nMismatched++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", k, outData, expD); end
        end
    endtask

    // Requester 1 sends a three-beat transfer while others are valid; the
    // lock keeps them out, then the pointer lands on 2 and later on 3.
    task automatic test_lock;
        doReset();
        reqData[1] = 8'h11;
        reqData[2] = 8'h22;
        reqValid   = 4'b0110;
        reqLast    = 4'b0100;
        #1;
        nCompared++; if (reqReady !== 4'b0010) begin nMismatched++; $display("[TB] FAIL lock_ready0: got %b want 0010", reqReady); end
        tick();
        nCompared++; if (outData !== 8'h11) begin nMismatched++; $display("[TB] FAIL lock_data0: got %h want 11", outData); end
        nCompared++; if (outLast !== 1'b0) begin nMismatched++; $display("[TB] FAIL lock_last0: got %b want 0", outLast); end
        nCompared++; if (outGrant !== 4'b0010) begin nMismatched++; $display("[TB] FAIL lock_grant0: got %b want 0010", outGrant); end

        reqValid   = 4'b0111;
        reqLast    = 4'b0101;
        reqData[1] = 8'h12;
        #1;
        nCompared++; if (reqReady !== 4'b0010) begin nMismatched++; $display("[TB] FAIL lock_ready1: got %b want 0010", reqReady); end
        tick();
        nCompared++; if (outData !== 8'h12) begin nMismatched++; $display("[TB] FAIL lock_data1: got %h want 12", outData); end
        nCompared++; if (outGrant !== 4'b0010) begin nMismatched++; $display("[TB] FAIL lock_grant1: got %b want 0010", outGrant); end

        reqLast    = 4'b0111;
        reqData[1] = 8'h13;
        #1;
        nCompared++; if (reqReady !== 4'b0010) begin nMismatched++; $display("[TB] FAIL lock_ready2: got %b want 0010", reqReady); end
        tick();
        nCompared++; if (outData !== 8'h13) begin nMismatched++; $display("[TB] FAIL lock_data2: got %h want 13", outData); end
        nCompared++; if (outLast !== 1'b1) begin nMismatched++; $display("[TB] FAIL lock_last2: got %b want 1", outLast); end

        reqValid = 4'b0101;
        reqLast  = 4'b0101;
        #1;
        nCompared++; if (reqReady !== 4'b0100) begin nMismatched++; $display("[TB] FAIL lock_ptr2_ready: got %b want 0100", reqReady); end
        tick();
        nCompared++; if (outData !== 8'h22) begin nMismatched++; $display("[TB] FAIL lock_req2_data: got %h want 22", outData); end
        nCompared++; if (outGrant !== 4'b0100) begin nMismatched++; $display("[TB] FAIL lock_req2_grant: got %b want 0100", outGrant); end

        reqValid = 4'b1111;
        reqLast  = 4'b1111;
        #1;
        nCompared++; if (reqReady !== 4'b1000) begin nMismatched++; $display("[TB] FAIL lock_ptr3_ready: got %b want 1000", reqReady); end
        tick();
        nCompared++; if (outGrant !== 4'b1000) begin nMismatched++; $display("[TB] FAIL lock_ptr3_grant: got %b want 1000", outGrant); end
    endtask

    // Locked owner 0 goes quiet for two cycles while requester 3 waits.
    task automatic test_stall_owner;
        doReset();
        reqData[0] = 8'h40;
        reqValid   = 4'b1001;
        reqLast    = 4'b0000;
        #1;
        nCompared++; if (reqReady !== 4'b0001) begin nMismatched++; $display("[TB] FAIL stall_ready_first: got %b want 0001", reqReady); end
        tick();
        nCompared++; if (outGrant !== 4'b0001) begin nMismatched++; $display("[TB] FAIL stall_grant_first: got %b want 0001", outGrant); end
        for (int k = 0; k < 2; k++) begin
            reqValid = 4'b1000;
            reqLast  = 4'b1000;
            #1;
            nCompared++; if (reqReady !== 4'b0001) begin nMismatched++; $display("[TB] FAIL stall_ready_idle[%0d]: got %b want 0001", k, reqReady); end
            tick();
            nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_valid_idle[%0d]: got %b want 0", k, outValid); end
        end
        reqValid   = 4'b1001;
        reqLast    = 4'b1001;
        reqData[0] = 8'h41;
        #1;
        nCompared++; if (reqReady !== 4'b0001) begin nMismatched++; $display("[TB] FAIL stall_ready_last: got %b want 0001", reqReady); end
        tick();
        nCompared++; if (outData !== 8'h41) begin nMismatched++; $display("[TB] FAIL stall_data_last: got %h want 41", outData); end
        nCompared++; if (outLast !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_last_flag: got %b want 1", outLast); end
        reqValid = 4'b1000;
        #1;
        nCompared++; if (reqReady !== 4'b1000) begin nMismatched++; $display("[TB] FAIL stall_ready_req3: got %b want 1000", reqReady); end
        tick();
        nCompared++; if (outGrant !== 4'b1000) begin nMismatched++; $display("[TB] FAIL stall_grant_req3: got %b want 1000", outGrant); end
    endtask

    // Downstream stalls for five cycles holding 0xA5.
    task automatic test_backpressure;
        doReset();
        reqData[0] = 8'hA5;
        reqValid   = 4'b0001;
        reqLast    = 4'b0001;
        #1;
        tick();
        nCompared++; if (outData !== 8'hA5) begin nMismatched++; $display("[TB] FAIL bp_load_data: got %h want a5", outData); end
        outReady   = 1'b0;
        reqValid   = 4'b0011;
        reqLast    = 4'b0011;
        reqData[0] = 8'h33;
        reqData[1] = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            #1;
            nCompared++; if (reqReady !== 4'b0000) begin nMismatched++; $display("[TB] FAIL bp_ready[%0d]: got %b want 0000", k, reqReady); end
            tick();
            nCompared++; if (outValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", k, outValid); end
            nCompared++; if (outData !== 8'hA5) begin nMismatched++; $display("[TB] FAIL bp_data[%0d]: got %h want a5", k, outData); end
            nCompared++; if (outGrant !== 4'b0001) begin nMismatched++; $display("[TB] FAIL bp_grant[%0d]: got %b want 0001", k, outGrant); end
        end
        outReady = 1'b1;
        #1;
        nCompared++; if (reqReady !== 4'b0010) begin nMismatched++; $display("[TB] FAIL bp_release_ready: got %b want 0010", reqReady); end
        tick();
        nCompared++; if (outData !== 8'h5A) begin nMismatched++; $display("[TB] FAIL bp_next_data: got %h want 5a", outData); end
        nCompared++; if (outGrant !== 4'b0010) begin nMismatched++; $display("[TB] FAIL bp_next_grant: got %b want 0010", outGrant); end
        reqValid = 4'b0000;
        tick();
        nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_drain_valid: got %b want 0", outValid); end
    endtask

    // Only requester 3 valid with pointer at zero: search wraps; pointer
    // returns to zero after its last beat.
    task automatic test_wrap;
        doReset();
        reqData[3] = 8'h3C;
        reqValid   = 4'b1000;
        reqLast    = 4'b1000;
        #1;
        nCompared++; if (reqReady !== 4'b1000) begin nMismatched++; $display("[TB] FAIL wrap_ready: got %b want 1000", reqReady); end
        tick();
        nCompared++; if (outData !== 8'h3C) begin nMismatched++; $display("[TB] FAIL wrap_data: got %h want 3c", outData); end
        reqValid = 4'b1111;
        reqLast  = 4'b1111;
        #1;
        nCompared++; if (reqReady !== 4'b0001) begin nMismatched++; $display("[TB] FAIL wrap_ptr0_ready: got %b want 0001", reqReady); end
        tick();
        nCompared++; if (outGrant !== 4'b0001) begin nMismatched++; $display("[TB] FAIL wrap_ptr0_grant: got %b want 0001", outGrant); end
    endtask

    // Reset while locked on requester 2 with a beat in the output register.
    task automatic test_reset_mid;
        doReset();
        reqData[2] = 8'h77;
        reqValid   = 4'b0100;
        reqLast    = 4'b0000;
        #1;
        tick();
        nCompared++; if (outGrant !== 4'b0100) begin nMismatched++; $display("[TB] FAIL rmid_grant: got %b want 0100", outGrant); end
        reqValid = 4'b1011;
        reqLast  = 4'b1111;
        #1;
        nCompared++; if (reqReady !== 4'b0100) begin nMismatched++; $display("[TB] FAIL rmid_locked_ready: got %b want 0100", reqReady); end
        tick();
        nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_locked_valid: got %b want 0", outValid); end
        reqValid = 4'b0100;
        reqLast  = 4'b0000;
        tick();
        nCompared++; if (outValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_pre_valid: got %b want 1", outValid); end
        rst      = 1'b1;
        reqValid = 4'b1111;
        reqLast  = 4'b1111;
        #1;
        nCompared++; if (reqReady !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rmid_ready_in_reset: got %b want 0000", reqReady); end
        tick();
        nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_valid: got %b want 0", outValid); end
        nCompared++; if (outGrant !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rmid_grant_clr: got %b want 0000", outGrant); end
        nCompared++; if (outData !== 8'h00) begin nMismatched++; $display("[TB] FAIL rmid_data_clr: got %h want 00", outData); end
        rst = 1'b0;
        #1;
        nCompared++; if (reqReady !== 4'b0001) begin nMismatched++; $display("[TB] FAIL rmid_after_ready: got %b want 0001", reqReady); end
        tick();
        nCompared++; if (outGrant !== 4'b0001) begin nMismatched++; $display("[TB] FAIL rmid_after_grant: got %b want 0001", outGrant); end
        nCompared++; if (outValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rmid_after_valid: got %b want 1", outValid); end
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = 4'b0000;
        reqLast  = 4'b0000;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reqData[i] = 8'h10 + 8'(i);
        end
        test_reset();
        test_round_robin();
        test_lock();
        test_stall_owner();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
